// File: rtl/timer_bus_master.sv
// timer_bus_master: expands ARM / SNAP / STOP / CLEAR commands into the
// halfword Avalon-MM register accesses of the 64-bit timer's 16-bit slave,
// and assembles the 64-bit snapshot plus status from SNAP reads.
// Build option: define TIMER_MASTER_AUTOCLEAR_EN to issue an automatic
// status clear (addr 0 write) after each m_irq rising edge.
module timer_bus_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [63:0]       cmd_period,
  input  logic              cmd_continuous,
  input  logic              cmd_irq_en,
  output logic              rsp_valid,
  output logic [63:0]       rsp_snapshot,
  output logic [1:0]        rsp_status,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              m_irq,
  output logic              timeout_pulse,
  output logic [15:0]       irq_count
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_RESP} state_t;
  typedef enum logic [1:0] {OP_ARM = 2'd0, OP_SNAP = 2'd1, OP_STOP = 2'd2, OP_CLEAR = 2'd3} op_t;

  localparam int unsigned LAST       = READ_LATENCY - 1;
  localparam logic [2:0]  TAG_STATUS = 3'd4;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [2:0]          step_q, step_d;
  logic [63:0]         period_q, period_d;
  logic [1:0]          mode_q, mode_d;      // {continuous, irq_en} of the accepted ARM
  logic [1:0]          shadow_q, shadow_d;  // mode bits of the last ARM, reused by STOP
  logic [ADDR_W-1:0]   m_address_q, m_address_d;
  logic                m_chipselect_q, m_chipselect_d;
  logic                m_write_n_q, m_write_n_d;
  logic [15:0]         m_writedata_q, m_writedata_d;
  logic [LAST:0]       tag_vld_q, tag_vld_d;
  logic [2:0]          tag_idx_q [READ_LATENCY];
  logic [2:0]          tag_idx_d [READ_LATENCY];
  logic [63:0]         acc_q, acc_d;
  logic [63:0]         rsp_snapshot_q, rsp_snapshot_d;
  logic [1:0]          rsp_status_q, rsp_status_d;
  logic                irq_prev_q, irq_prev_d;
  logic                timeout_pulse_q, timeout_pulse_d;
  logic [15:0]         irq_count_q, irq_count_d;
  logic                irq_rise;
  logic [ADDR_W+15:0]  item;
`ifdef TIMER_MASTER_AUTOCLEAR_EN
  logic                pending_q, pending_d;
`endif

  // {address, data} of write number idx within a command's write list
  function automatic logic [ADDR_W+15:0] write_item(input op_t op, input logic [2:0] idx,
                                                    input logic [63:0] per, input logic [1:0] mode,
                                                    input logic [1:0] shadow);
    logic [ADDR_W+15:0] it;
    case (op)
      OP_ARM: begin
        case (idx)
          3'd0:    it = {ADDR_W'(2), per[15:0]};
          3'd1:    it = {ADDR_W'(3), per[31:16]};
          3'd2:    it = {ADDR_W'(4), per[47:32]};
          3'd3:    it = {ADDR_W'(5), per[63:48]};
          default: it = {ADDR_W'(1), 12'h000, 2'b01, mode};
        endcase
      end
      OP_SNAP: it = {ADDR_W'(6), 16'h0000};
      OP_STOP: it = {ADDR_W'(1), 12'h000, 2'b10, shadow};
      default: it = {ADDR_W'(0), 16'h0000};
    endcase
    return it;
  endfunction

  function automatic logic [ADDR_W-1:0] read_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return ADDR_W'(6);
      3'd1:    return ADDR_W'(7);
      3'd2:    return ADDR_W'(8);
      3'd3:    return ADDR_W'(9);
      default: return ADDR_W'(0);
    endcase
  endfunction

  function automatic logic [2:0] addr_tag(input logic [ADDR_W-1:0] a);
    case (a)
      ADDR_W'(6): return 3'd0;
      ADDR_W'(7): return 3'd1;
      ADDR_W'(8): return 3'd2;
      ADDR_W'(9): return 3'd3;
      default:    return TAG_STATUS;
    endcase
  endfunction

  // Next-state, bus cycle generation, read-data routing and irq edge counting
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    step_d          = step_q;
    period_d        = period_q;
    mode_d          = mode_q;
    shadow_d        = shadow_q;
    m_address_d     = m_address_q;
    m_chipselect_d  = 1'b0;
    m_write_n_d     = 1'b1;
    m_writedata_d   = m_writedata_q;
    acc_d           = acc_q;
    rsp_snapshot_d  = rsp_snapshot_q;
    rsp_status_d    = rsp_status_q;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    item            = '0;
    irq_rise        = m_irq && !irq_prev_q;
    irq_prev_d      = m_irq;
    timeout_pulse_d = irq_rise;
    irq_count_d     = irq_count_q + 16'(irq_rise);
`ifdef TIMER_MASTER_AUTOCLEAR_EN
    pending_d       = pending_q;
`endif

    // Tag of the read presented this cycle travels with it until its data returns
    tag_vld_d[0] = m_chipselect_q && m_write_n_q;
    tag_idx_d[0] = addr_tag(m_address_q);
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    if (tag_vld_q[LAST]) begin
      case (tag_idx_q[LAST])
        3'd0:    acc_d[15:0]  = m_readdata;
        3'd1:    acc_d[31:16] = m_readdata;
        3'd2:    acc_d[47:32] = m_readdata;
        3'd3:    acc_d[63:48] = m_readdata;
        default: begin
          rsp_snapshot_d = acc_q;
          rsp_status_d   = m_readdata[1:0];
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
`ifdef TIMER_MASTER_AUTOCLEAR_EN
        if (pending_q) begin
          m_chipselect_d = 1'b1;
          m_write_n_d    = 1'b0;
          m_address_d    = '0;
          m_writedata_d  = '0;
          pending_d      = 1'b0;
        end else begin
          cmd_ready = 1'b1;
        end
`else
        cmd_ready = 1'b1;
`endif
        if (cmd_valid && cmd_ready) begin
          op_d     = op_t'(cmd_op);
          period_d = cmd_period;
          mode_d   = {cmd_continuous, cmd_irq_en};
          if (op_t'(cmd_op) == OP_ARM) shadow_d = {cmd_continuous, cmd_irq_en};
          item           = write_item(op_t'(cmd_op), 3'd0, cmd_period,
                                      {cmd_continuous, cmd_irq_en}, shadow_q);
          m_chipselect_d = 1'b1;
          m_write_n_d    = 1'b0;
          {m_address_d, m_writedata_d} = item;
          step_d         = 3'd1;
          state_d        = S_WRITE;
        end
      end
      S_WRITE: begin
        if (step_q < ((op_q == OP_ARM) ? 3'd5 : 3'd1)) begin
          item           = write_item(op_q, step_q, period_q, mode_q, shadow_q);
          m_chipselect_d = 1'b1;
          m_write_n_d    = 1'b0;
          {m_address_d, m_writedata_d} = item;
          step_d         = step_q + 3'd1;
        end else if (op_q == OP_SNAP) begin
          m_chipselect_d = 1'b1;
          m_address_d    = read_addr(3'd0);
          step_d         = 3'd1;
          state_d        = S_READ;
        end else begin
          state_d = S_RESP;
        end
      end
      S_READ: begin
        if (step_q < 3'd5) begin
          m_chipselect_d = 1'b1;
          m_address_d    = read_addr(step_q);
          step_d         = step_q + 3'd1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tag_vld_q[LAST] && tag_idx_q[LAST] == TAG_STATUS) state_d = S_RESP;
      end
      default: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
    endcase

`ifdef TIMER_MASTER_AUTOCLEAR_EN
    if (irq_rise) pending_d = 1'b1;
`endif
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      op_q            <= OP_ARM;
      step_q          <= '0;
      period_q        <= '0;
      mode_q          <= '0;
      shadow_q        <= '0;
      m_address_q     <= '0;
      m_chipselect_q  <= 1'b0;
      m_write_n_q     <= 1'b1;
      m_writedata_q   <= '0;
      tag_vld_q       <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_idx_q[i] <= '0;
      acc_q           <= '0;
      rsp_snapshot_q  <= '0;
      rsp_status_q    <= '0;
      irq_prev_q      <= 1'b0;
      timeout_pulse_q <= 1'b0;
      irq_count_q     <= '0;
`ifdef TIMER_MASTER_AUTOCLEAR_EN
      pending_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      step_q          <= step_d;
      period_q        <= period_d;
      mode_q          <= mode_d;
      shadow_q        <= shadow_d;
      m_address_q     <= m_address_d;
      m_chipselect_q  <= m_chipselect_d;
      m_write_n_q     <= m_write_n_d;
      m_writedata_q   <= m_writedata_d;
      tag_vld_q       <= tag_vld_d;
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_idx_q[i] <= tag_idx_d[i];
      acc_q           <= acc_d;
      rsp_snapshot_q  <= rsp_snapshot_d;
      rsp_status_q    <= rsp_status_d;
      irq_prev_q      <= irq_prev_d;
      timeout_pulse_q <= timeout_pulse_d;
      irq_count_q     <= irq_count_d;
`ifdef TIMER_MASTER_AUTOCLEAR_EN
      pending_q       <= pending_d;
`endif
    end
  end

  assign rsp_snapshot  = rsp_snapshot_q;
  assign rsp_status    = rsp_status_q;
  assign m_address     = m_address_q;
  assign m_chipselect  = m_chipselect_q;
  assign m_write_n     = m_write_n_q;
  assign m_writedata   = m_writedata_q;
  assign timeout_pulse = timeout_pulse_q;
  assign irq_count     = irq_count_q;

endmodule

// File: doc/timer_bus_master.md
# timer_bus_master

Avalon-MM master sequencer that drives the 16-bit register slave of the 64-bit interval/performance timer. A simple command port issues four high-level operations: arm, snapshot, stop, clear status. The block expands each into the timer's halfword register write/read sequence and returns the assembled 64-bit snapshot and status. It sits between on-chip control logic (e.g. the encryption datapath's profiling hooks) and the timer, so no CPU is needed to measure cycles.

## Interface
- READ_LATENCY, 1, cycles from read address presentation to valid m_readdata (1..3).
- ADDR_W, 4, width of m_address.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=ARM, 1=SNAP, 2=STOP, 3=CLEAR.
- cmd_period  in  64  ARM period value.
- cmd_continuous  in  1  ARM continuous-mode bit.
- cmd_irq_en  in  1  ARM interrupt-enable bit.
- rsp_valid  out  1  one-cycle pulse at command completion.
- rsp_snapshot  out  64  snapshot from the last SNAP; held until the next SNAP.
- rsp_status  out  2  {running, timeout} from the last SNAP.
- m_address  out  ADDR_W  slave register index.
- m_chipselect  out  1  bus cycle active.
- m_write_n  out  1  active-low write.
- m_writedata  out  16  write data.
- m_readdata  in  16  read data.
- m_irq  in  1  timer interrupt, same clock domain.
- timeout_pulse  out  1  one-cycle pulse on m_irq rising edge.
- irq_count  out  16  count of m_irq rising edges, wraps 0xFFFF->0.

## Operation
- FSM states:
  - IDLE: cmd_ready=1.
  - WRITE: issues the write list.
  - READ: issues reads.
  - DRAIN: waits for outstanding read data.
  - RESP: rsp_valid=1 for one cycle, then IDLE.
- Command accepted on cmd_valid && cmd_ready. Operands are registered at acceptance; later changes are ignored.
- ARM writes five registers, one per cycle:
  - addr 2 = period[15:0]
  - addr 3 = period[31:16]
  - addr 4 = period[47:32]
  - addr 5 = period[63:48]
  - addr 1 = {12'b0, stop=0, start=1, cmd_continuous, cmd_irq_en}
  - ARM also latches the continuous and irq_en bits into a shadow register, reset value 0.
- SNAP sequence:
  - Write addr 6, data 0x0000.
  - Then issue reads back-to-back to addr 6, 7, 8, 9, 0.
  - A tag shift register of depth READ_LATENCY routes each returning m_readdata word: addr 6 -> snapshot[15:0], addr 7 -> [31:16], addr 8 -> [47:32], addr 9 -> [63:48], addr 0 -> status[1:0].
- STOP writes addr 1 = {stop=1, start=0, shadow continuous, shadow irq_en} = 0x8 | shadow.
- CLEAR writes addr 0, data 0x0000.
- Between bus cycles: m_chipselect=0, m_write_n=1, m_address and m_writedata hold their last values.
- Reset mid-operation: the sequence is abandoned, every output returns to its reset value, and no rsp_valid is produced.
- Reset values:
  - cmd_ready=1, rsp_valid=0.
  - rsp_snapshot=0, rsp_status=0.
  - m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0.
  - timeout_pulse=0, irq_count=0.
  - m_irq edge-detect register=0.

## Timing
- Acceptance at edge 0; first bus cycle in cycle 1. No waitrequest: every bus cycle is exactly one clock.
- ARM: writes in cycles 1-5; rsp_valid in cycle 6.
- STOP and CLEAR: write in cycle 1; rsp_valid in cycle 2.
- SNAP:
  - Write in cycle 1; reads in cycles 2-6.
  - Status word sampled at end of cycle 6+READ_LATENCY.
  - rsp_snapshot and rsp_status update together in cycle 7+READ_LATENCY, coincident with rsp_valid; never partially updated.
- Back-to-back commands: next acceptance is possible in the cycle after rsp_valid.
- timeout_pulse is asserted the cycle after m_irq is first sampled high. irq_count increments in the same cycle.
- m_irq edges are counted in every state, including during reset release.

## Configuration
- TIMER_MASTER_AUTOCLEAR_EN defined:
  - Each m_irq rising edge sets a pending flag.
  - In IDLE with the flag set, the block issues a CLEAR write (addr 0) with no rsp_valid and clears the flag. cmd_ready=0 during that cycle.
  - If an edge arrives while busy, the clear occurs in the first IDLE cycle, ahead of any waiting command.
  - A second edge while the flag is already set does not queue a second clear.
- Undefined: no automatic bus activity; m_irq only drives timeout_pulse and irq_count.

## Test plan
- ARM, period 0x0000_0001_0002_0003, cont=1, irq_en=1 -> writes (2,0x0003), (3,0x0002), (4,0x0001), (5,0x0000), (1,0x0007) in cycles 1-5; rsp_valid in cycle 6.
- SNAP with READ_LATENCY=1; slave model returns 0x1111, 0x2222, 0x3333, 0x4444, 0x0002 -> rsp_snapshot=0x4444_3333_2222_1111, rsp_status=2'b10, rsp_valid in cycle 8.
- SNAP with READ_LATENCY=3, same data -> identical result, rsp_valid in cycle 10; no extra bus cycles.
- ARM cont=1 irq_en=0, then STOP -> addr 1 write data 0x000A; then CLEAR -> addr 0 write data 0x0000.
- m_irq toggled high three times with a SNAP in flight, autoclear enabled -> irq_count=3 and three timeout_pulses. Exactly one addr 0 write occurs after the SNAP's rsp_valid, before the next command is accepted.
- reset_n asserted during ARM cycle 3 -> outputs at reset values immediately; no rsp_valid; next ARM after release runs the full five writes.
